// File: rtl/lcd_pkg.sv
// Shared constants, command classes and address helpers for the HD44780-style
// character-LCD responder.
package lcd_pkg;

    localparam int CELLS = 32;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] ADDR_LINE1 = 8'h40;

    localparam logic [7:0] MASK_SET_DDRAM = 8'h80;
    localparam logic [7:0] MASK_SET_CGRAM = 8'h40;
    localparam logic [7:0] MASK_FUNC_SET  = 8'h20;
    localparam logic [7:0] MASK_SHIFT     = 8'h10;
    localparam logic [7:0] MASK_DISP_CTRL = 8'h08;
    localparam logic [7:0] MASK_ENTRY     = 8'h04;
    localparam logic [7:0] MASK_HOME      = 8'h02;
    localparam logic [7:0] MASK_CLEAR     = 8'h01;

    typedef enum logic {
        IDLE,
        CLEAR
    } lcd_state_e;

    typedef enum logic [2:0] {
        CMD_IGNORE,
        CMD_SET_DDRAM,
        CMD_FUNC_SET,
        CMD_DISP_CTRL,
        CMD_ENTRY,
        CMD_HOME,
        CMD_CLEAR
    } lcd_cmd_e;

    // The highest set bit selects the command class.
    function automatic lcd_cmd_e decode_cmd(input logic [7:0] d);
        if ((d & MASK_SET_DDRAM) != 8'h00) return CMD_SET_DDRAM;
        if ((d & MASK_SET_CGRAM) != 8'h00) return CMD_IGNORE;
        if ((d & MASK_FUNC_SET)  != 8'h00) return CMD_FUNC_SET;
        if ((d & MASK_SHIFT)     != 8'h00) return CMD_IGNORE;
        if ((d & MASK_DISP_CTRL) != 8'h00) return CMD_DISP_CTRL;
        if ((d & MASK_ENTRY)     != 8'h00) return CMD_ENTRY;
        if ((d & MASK_HOME)      != 8'h00) return CMD_HOME;
        if ((d & MASK_CLEAR)     != 8'h00) return CMD_CLEAR;
        return CMD_IGNORE;
    endfunction

    // DDRAM address byte (0x00-0x0F / 0x40-0x4F) to {line, column} cell index.
    function automatic logic [4:0] cell_index(input logic [7:0] addr);
        return {addr[6], addr[3:0]};
    endfunction

    function automatic logic [6:0] ddram_addr(input logic [4:0] idx);
        return 7'(idx[4] ? ADDR_LINE1 : 8'h00) | 7'(idx[3:0]);
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 character shadow: one write port, a registered host read port and a
// combinational bus read port.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_we,
    input  logic [4:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [4:0] i_rd_idx,
    output logic [7:0] o_rd_char,
    input  logic [4:0] i_bus_addr,
    output logic [7:0] o_bus_data
);

    logic [7:0] r_cells [CELLS];
    logic [7:0] r_rd_char;

    // NOTE: the array is reset on purpose so a reset mid-clear leaves a blank
    // screen; this forces flops rather than a RAM macro, which is fine at 32 cells.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) begin
                r_cells[i] <= CHAR_SPACE;
            end
            r_rd_char <= CHAR_SPACE;
        end else begin
            if (i_we) begin
                r_cells[i_waddr] <= i_wdata;
            end
            r_rd_char <= r_cells[i_rd_idx];
        end
    end

    assign o_rd_char  = r_rd_char;
    assign o_bus_data = r_cells[i_bus_addr];

endmodule

// File: rtl/lcd_char_receiver.sv
// HD44780-style bus responder: captures transfers on the falling edge of
// lcd_en, decodes commands and data, and runs the clear sweep.
module lcd_char_receiver
    import lcd_pkg::*;
#(
    parameter int CLEAR_CYCLES = 32
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    output logic [7:0] lcd_dout,
    output logic       lcd_doe,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char,
    output logic       disp_on,
    output logic       two_line,
    output logic       busy,
    output logic       wr_strobe,
    output logic       cmd_strobe,
    output logic       ovr
);

    localparam logic [4:0] CLR_LAST = 5'(CLEAR_CYCLES - 1);

    lcd_state_e r_state, w_state_nxt;

    logic       r_en_q, r_rs, r_rw;
    logic [7:0] r_data;
    logic [4:0] r_ac, r_clr_cnt;
    logic       r_inc, r_disp_on, r_two_line;
    logic       r_wr_strobe, r_cmd_strobe, r_ovr;

    logic       w_fall, w_busy, w_status_rd, w_accept;
    logic       w_cmd, w_wr, w_data_rd, w_drop;
    lcd_cmd_e   w_cmd_class;
    logic [4:0] w_ac_step;
    logic       w_mem_we;
    logic [4:0] w_mem_addr;
    logic [7:0] w_mem_wdata, w_bus_data, w_dout;

    assign w_fall      = r_en_q & ~lcd_en;
    assign w_busy      = (r_state == CLEAR);
    assign w_status_rd = ~r_rs & r_rw;
    assign w_accept    = w_fall & (~w_busy | w_status_rd);
    assign w_drop      = w_fall & w_busy & ~w_status_rd;
    assign w_cmd       = w_accept & ~r_rs & ~r_rw;
    assign w_wr        = w_accept &  r_rs & ~r_rw;
    assign w_data_rd   = w_accept &  r_rs &  r_rw;
    assign w_cmd_class = decode_cmd(r_data);
    assign w_ac_step   = r_inc ? r_ac + 5'd1 : r_ac - 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = w_wr;
        w_mem_addr  = r_ac;
        w_mem_wdata = r_data;
        case (r_state)
            IDLE: begin
                if (w_cmd && w_cmd_class == CMD_CLEAR) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_cnt;
                w_mem_wdata = CHAR_SPACE;
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before this edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_q       <= 1'b0;
            r_rs         <= 1'b0;
            r_rw         <= 1'b0;
            r_data       <= 8'h00;
            r_ac         <= 5'd0;
            r_clr_cnt    <= 5'd0;
            r_inc        <= 1'b1;
            r_disp_on    <= 1'b0;
            r_two_line   <= 1'b0;
            r_wr_strobe  <= 1'b0;
            r_cmd_strobe <= 1'b0;
            r_ovr        <= 1'b0;
        end else begin
            r_en_q       <= lcd_en;
            r_wr_strobe  <= w_wr;
            r_cmd_strobe <= w_cmd;
            r_ovr        <= w_drop;
            if (lcd_en) begin
                r_rs   <= lcd_rs;
                r_rw   <= lcd_rw;
                r_data <= lcd_data;
            end
            if (w_busy) begin
                r_clr_cnt <= r_clr_cnt + 5'd1;
            end
            if (w_cmd) begin
                case (w_cmd_class)
                    CMD_SET_DDRAM: r_ac       <= cell_index(r_data);
                    CMD_FUNC_SET:  r_two_line <= r_data[3];
                    CMD_DISP_CTRL: r_disp_on  <= r_data[2];
                    CMD_ENTRY:     r_inc      <= r_data[1];
                    CMD_HOME:      r_ac       <= 5'd0;
                    CMD_CLEAR: begin
                        r_ac      <= 5'd0;
                        r_inc     <= 1'b1;
                        r_clr_cnt <= 5'd0;
                    end
                    default: ;
                endcase
            end else if (w_wr || w_data_rd) begin
                r_ac <= w_ac_step;
            end
        end
    end

    always_comb begin
        w_dout = 8'h00;
        if (lcd_doe) begin
            w_dout = r_rs ? w_bus_data : {w_busy, ddram_addr(r_ac)};
        end
    end

    lcd_ddram u_ddram (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_mem_we),
        .i_waddr    (w_mem_addr),
        .i_wdata    (w_mem_wdata),
        .i_rd_idx   (rd_idx),
        .o_rd_char  (rd_char),
        .i_bus_addr (r_ac),
        .o_bus_data (w_bus_data)
    );

    assign lcd_doe    = lcd_en & r_rw;
    assign lcd_dout   = w_dout;
    assign busy       = w_busy;
    assign disp_on    = r_disp_on;
    assign two_line   = r_two_line;
    assign wr_strobe  = r_wr_strobe;
    assign cmd_strobe = r_cmd_strobe;
    assign ovr        = r_ovr;

endmodule

// File: tb/tb_lcd_char_receiver.sv
// Directed bench for lcd_char_receiver: bus writes/reads, wrap, clear/overrun
// and reset mid-clear, each checked against hand-computed values.
module tb_lcd_char_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_en = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [4:0] rd_idx = 5'd0;
    logic [7:0] lcd_dout, rd_char;
    logic       lcd_doe, disp_on, two_line, busy, wr_strobe, cmd_strobe, ovr;

    int n_vec  = 0;
    int n_miss = 0;
    int n_cmd  = 0;
    int n_wr   = 0;
    int n_ovr  = 0;

    lcd_char_receiver #(.CLEAR_CYCLES(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lcd_en     (lcd_en),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .lcd_dout   (lcd_dout),
        .lcd_doe    (lcd_doe),
        .rd_idx     (rd_idx),
        .rd_char    (rd_char),
        .disp_on    (disp_on),
        .two_line   (two_line),
        .busy       (busy),
        .wr_strobe  (wr_strobe),
        .cmd_strobe (cmd_strobe),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_strobe) n_cmd++;
        if (wr_strobe)  n_wr++;
        if (ovr)        n_ovr++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] d);
        step();
        lcd_en = 1'b1; lcd_rs = rs; lcd_rw = 1'b0; lcd_data = d;
        step();
        lcd_en = 1'b0;
        step();
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] v, output logic oe);
        step();
        lcd_en = 1'b1; lcd_rs = rs; lcd_rw = 1'b1;
        step();
        v  = lcd_dout;
        oe = lcd_doe;
        lcd_en = 1'b0;
        step();
        lcd_rw = 1'b0;
    endtask

    task automatic peek(input logic [4:0] idx, output logic [7:0] v);
        rd_idx = idx;
        step();
        v = rd_char;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        step(); step();
        n_vec++; if (busy !== 1'b0)     begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (disp_on !== 1'b0)  begin n_miss++; $display("FAIL reset_disp_on: got %b want 0", disp_on); end
        n_vec++; if (two_line !== 1'b0) begin n_miss++; $display("FAIL reset_two_line: got %b want 0", two_line); end
        n_vec++; if ({wr_strobe, cmd_strobe, ovr} !== 3'b000)
            begin n_miss++; $display("FAIL reset_strobes: got %b want 000", {wr_strobe, cmd_strobe, ovr}); end
        n_vec++; if ({lcd_doe, lcd_dout} !== 9'h000)
            begin n_miss++; $display("FAIL reset_dout: got doe=%b dout=%h want 0/00", lcd_doe, lcd_dout); end
        n_vec++; if (rd_char !== 8'h20) begin n_miss++; $display("FAIL reset_rd_char: got %h want 20", rd_char); end
        rst_n = 1'b1;
        step();
        peek(5'd31, v);
        n_vec++; if (v !== 8'h20) begin n_miss++; $display("FAIL reset_cell31: got %h want 20", v); end
    endtask

    task automatic test_init_text();
        logic [7:0] exp_c [4] = '{8'h2B, 8'h31, 8'h32, 8'h33};
        logic [7:0] v;
        logic oe;
        int c0, w0;
        c0 = n_cmd; w0 = n_wr;
        bus_write(1'b0, 8'h80);
        bus_write(1'b0, 8'h38);
        bus_write(1'b0, 8'h0C);
        for (int i = 0; i < 4; i++) bus_write(1'b1, exp_c[i]);
        for (int i = 0; i < 4; i++) begin
            peek(5'(i), v);
            n_vec++; if (v !== exp_c[i]) begin n_miss++; $display("FAIL init_cell%0d: got %h want %h", i, v, exp_c[i]); end
        end
        n_vec++; if (two_line !== 1'b1) begin n_miss++; $display("FAIL init_two_line: got %b want 1", two_line); end
        n_vec++; if (disp_on !== 1'b1)  begin n_miss++; $display("FAIL init_disp_on: got %b want 1", disp_on); end
        n_vec++; if (n_cmd - c0 != 3)   begin n_miss++; $display("FAIL init_cmd_strobes: got %0d want 3", n_cmd - c0); end
        n_vec++; if (n_wr - w0 != 4)    begin n_miss++; $display("FAIL init_wr_strobes: got %0d want 4", n_wr - w0); end
        bus_read(1'b0, v, oe);
        n_vec++; if (v !== 8'h04 || oe !== 1'b1)
            begin n_miss++; $display("FAIL init_status: got doe=%b dout=%h want 1/04", oe, v); end
    endtask

    task automatic test_line1();
        logic [7:0] v;
        logic oe;
        bus_write(1'b0, 8'hC0);
        bus_write(1'b1, 8'h2D);
        peek(5'd16, v);
        n_vec++; if (v !== 8'h2D) begin n_miss++; $display("FAIL line1_cell16: got %h want 2D", v); end
        bus_read(1'b0, v, oe);
        n_vec++; if (v !== 8'h41) begin n_miss++; $display("FAIL line1_status: got %h want 41", v); end
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        logic oe;
        int o0;
        o0 = n_ovr;
        bus_write(1'b0, 8'h8F);
        bus_write(1'b1, 8'h41);
        bus_write(1'b1, 8'h42);
        peek(5'd15, v);
        n_vec++; if (v !== 8'h41) begin n_miss++; $display("FAIL wrap_cell15: got %h want 41", v); end
        peek(5'd16, v);
        n_vec++; if (v !== 8'h42) begin n_miss++; $display("FAIL wrap_cell16: got %h want 42", v); end
        bus_write(1'b0, 8'h04);
        bus_write(1'b0, 8'h80);
        bus_write(1'b1, 8'h5A);
        peek(5'd0, v);
        n_vec++; if (v !== 8'h5A) begin n_miss++; $display("FAIL wrap_cell0: got %h want 5A", v); end
        bus_read(1'b0, v, oe);
        n_vec++; if (v !== 8'h4F) begin n_miss++; $display("FAIL wrap_dec_ac31: got %h want 4F", v); end
        bus_write(1'b0, 8'h06);
        bus_write(1'b1, 8'h7E);
        peek(5'd31, v);
        n_vec++; if (v !== 8'h7E) begin n_miss++; $display("FAIL wrap_cell31: got %h want 7E", v); end
        bus_read(1'b0, v, oe);
        n_vec++; if (v !== 8'h00) begin n_miss++; $display("FAIL wrap_inc_ac0: got %h want 00", v); end
        bus_write(1'b0, 8'h9A);
        bus_read(1'b0, v, oe);
        n_vec++; if (v !== 8'h0A) begin n_miss++; $display("FAIL wrap_ddram_d54: got %h want 0A", v); end
        n_vec++; if (n_ovr != o0) begin n_miss++; $display("FAIL wrap_no_ovr: got %0d pulses want 0", n_ovr - o0); end
        bus_write(1'b0, 8'h02);
        bus_read(1'b0, v, oe);
        n_vec++; if (v !== 8'h00) begin n_miss++; $display("FAIL wrap_home: got %h want 00", v); end
    endtask

    task automatic test_data_read();
        logic [7:0] v;
        logic oe;
        bus_read(1'b1, v, oe);
        n_vec++; if (v !== 8'h5A || oe !== 1'b1)
            begin n_miss++; $display("FAIL data_read: got doe=%b dout=%h want 1/5A", oe, v); end
        bus_read(1'b0, v, oe);
        n_vec++; if (v !== 8'h01) begin n_miss++; $display("FAIL data_read_ac: got %h want 01", v); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        logic oe;
        int w0;
        w0 = n_wr;
        for (int i = 0; i < 3; i++) begin
            step();
            lcd_en = 1'b1; lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h61 + 8'(i);
            step();
            lcd_en = 1'b0;
        end
        step(); step();
        for (int i = 1; i <= 3; i++) begin
            peek(5'(i), v);
            n_vec++; if (v !== 8'h60 + 8'(i)) begin n_miss++; $display("FAIL b2b_cell%0d: got %h want %h", i, v, 8'h60 + 8'(i)); end
        end
        n_vec++; if (n_wr - w0 != 3) begin n_miss++; $display("FAIL b2b_wr_strobes: got %0d want 3", n_wr - w0); end
        bus_read(1'b0, v, oe);
        n_vec++; if (v !== 8'h04) begin n_miss++; $display("FAIL b2b_ac: got %h want 04", v); end
    endtask

    task automatic test_clear();
        logic [7:0] v;
        logic oe;
        int busy_cnt, o0;
        bus_write(1'b0, 8'h04);
        o0 = n_ovr;
        busy_cnt = 0;
        step();
        lcd_en = 1'b1; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01;
        step();
        lcd_en = 1'b0;
        step();
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cnt++;
            if (k == 4) begin lcd_en = 1'b1; lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h55; end
            if (k == 5) lcd_en = 1'b0;
            if (k == 6) begin
                n_vec++; if (ovr !== 1'b1) begin n_miss++; $display("FAIL clear_ovr_pulse: got %b want 1", ovr); end
                lcd_en = 1'b1; lcd_rs = 1'b0; lcd_rw = 1'b1;
            end
            if (k == 7) begin
                n_vec++; if (lcd_doe !== 1'b1 || lcd_dout !== 8'h80)
                    begin n_miss++; $display("FAIL clear_status_busy: got doe=%b dout=%h want 1/80", lcd_doe, lcd_dout); end
            end
            if (k == 8) lcd_en = 1'b0;
            if (k == 9) begin
                lcd_rw = 1'b0;
                n_vec++; if (ovr !== 1'b0) begin n_miss++; $display("FAIL clear_status_ovr: got %b want 0", ovr); end
            end
            if (k == 32) begin
                n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL clear_busy_last: got %b want 1", busy); end
            end
            if (k == 33) begin
                n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL clear_busy_fall: got %b want 0", busy); end
            end
            step();
        end
        n_vec++; if (busy_cnt != 32)    begin n_miss++; $display("FAIL clear_busy_len: got %0d want 32", busy_cnt); end
        n_vec++; if (n_ovr - o0 != 1)   begin n_miss++; $display("FAIL clear_ovr_count: got %0d want 1", n_ovr - o0); end
        for (int i = 0; i < 32; i++) begin
            peek(5'(i), v);
            n_vec++; if (v !== 8'h20) begin n_miss++; $display("FAIL clear_cell%0d: got %h want 20", i, v); end
        end
        bus_write(1'b1, 8'h41);
        bus_read(1'b0, v, oe);
        n_vec++; if (v !== 8'h01) begin n_miss++; $display("FAIL clear_inc_restored: got %h want 01", v); end
    endtask

    task automatic test_reset_mid_clear();
        logic [7:0] v;
        logic oe;
        bus_write(1'b0, 8'h0C);
        bus_write(1'b1, 8'h11);
        bus_write(1'b0, 8'h01);
        for (int k = 1; k < 10; k++) step();
        n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL rmc_busy_before: got %b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0)    begin n_miss++; $display("FAIL rmc_busy_async: got %b want 0", busy); end
        n_vec++; if (disp_on !== 1'b0) begin n_miss++; $display("FAIL rmc_disp_on: got %b want 0", disp_on); end
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            peek(5'(i), v);
            n_vec++; if (v !== 8'h20) begin n_miss++; $display("FAIL rmc_cell%0d: got %h want 20", i, v); end
        end
        bus_read(1'b0, v, oe);
        n_vec++; if (v !== 8'h00) begin n_miss++; $display("FAIL rmc_status: got %h want 00", v); end
    endtask

    initial begin
        test_reset();
        test_init_text();
        test_line1();
        test_wrap();
        test_data_read();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lcd_char_receiver.md
# lcd_char_receiver

- Synthesizable responder for the HD44780-style 8-bit character-LCD bus (`lcd_en`, `lcd_rs`, `lcd_rw`, `lcd_data`) that our calculator front-ends drive.
- Decodes commands and data writes into a 2×16 DDRAM shadow with entry-mode and display state, and answers busy-flag and data reads.
- Gives the FPGA design and testbenches a cycle-accurate on-chip copy of the screen, readable through a host port.

## Interface
Parameters:
- `CLEAR_CYCLES`, default 32: busy duration of the clear command; equals the cell count and must stay 32.

Ports:
- `clk`  in  1  system clock; the LCD bus is driven synchronously in this domain.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `lcd_en`  in  1  enable strobe; a transfer completes on its falling edge.
- `lcd_rs`  in  1  0 = command/status, 1 = data.
- `lcd_rw`  in  1  0 = write, 1 = read.
- `lcd_data`  in  8  write data.
- `lcd_dout`  out  8  read data.
- `lcd_doe`  out  1  read-data output enable.
- `rd_idx`  in  5  host cell index; {line, column}.
- `rd_char`  out  8  contents of cell `rd_idx`, registered.
- `disp_on`  out  1  display-control D bit.
- `two_line`  out  1  function-set N bit.
- `busy`  out  1  clear in progress.
- `wr_strobe`  out  1  one-cycle pulse per accepted data write.
- `cmd_strobe`  out  1  one-cycle pulse per accepted command.
- `ovr`  out  1  one-cycle pulse when a transfer is dropped because `busy` is high.

## Operation
- **Capture:** `en_q` registers `lcd_en`.
  - While `lcd_en`=1, latch `rs`, `rw` and `data` every cycle.
  - Falling edge (`en_q`=1, `lcd_en`=0) executes the latched transfer once.
- **State:** 32×8 cell array, 5-bit address counter `ac`, `inc` (entry I/D), `disp_on`, `two_line`, 5-bit clear counter.
- **Command decode** (rs=0, rw=0, priority on the highest set bit):
  - 1xxxxxxx: `ac` = {d[6], d[3:0]}. If d[5:4] is nonzero the address is still taken and `ovr` does not pulse.
  - 01xxxxxx: CGRAM address; ignored, strobe only.
  - 001xxxxx: `two_line` = d[3].
  - 0001xxxx: cursor/display shift; ignored.
  - 00001xxx: `disp_on` = d[2].
  - 000001xx: `inc` = d[1].
  - 0000001x: return home, `ac` = 0.
  - 00000001: clear. Enters CLEAR; `ac` = 0, `inc` = 1.
- **Data write** (rs=1, rw=0): `cell[ac]` = data; `ac` = `ac`±1 modulo 32.
  - Index 15 rolls to 16 (line 1), index 31 to 0, and 0 decrements to 31.
- **Reads** (rw=1): `lcd_doe` = `lcd_en` & latched rw.
  - rs=0: `lcd_dout` = {`busy`, `ac`[4], 2'b0, `ac`[3:0]}, i.e. the DDRAM address 0x00–0x0F or 0x40–0x4F.
  - rs=1: `lcd_dout` = `cell[ac]`; `ac` advances on the falling edge.
- **State machine:**
  - IDLE → CLEAR on a clear command.
  - CLEAR writes 0x20 to `cell[cnt]`, one cell per cycle, over `CLEAR_CYCLES` cycles, then returns to IDLE.
- **During CLEAR:** a falling-edge transfer other than a status read is dropped and `ovr` pulses. Status reads are always honored.

## Timing
- **Reset values:**
  - All cells 0x20; `ac` = 0; `inc` = 1; `disp_on` = 0; `two_line` = 0.
  - FSM in IDLE; `busy` = 0; all strobes 0.
  - `lcd_dout` = 0; `lcd_doe` = 0; `rd_char` = 0x20.
- **Falling-edge transfers:** a transfer detected in cycle t updates state and pulses its strobe in cycle t+1.
- **Clear:** `busy` is high from t+1 through t+32. The cells are all 0x20 when `busy` falls.
- **`rd_char`:** one-cycle latency from `rd_idx`. A host read of the cell being written in the same cycle returns the old value.
- **`lcd_dout`:** combinational from latched state while `lcd_doe` is high.
- **Reset during CLEAR:** aborts immediately to reset values; no partial state survives.
- **Back-to-back transfers:** require ≥1 cycle of `lcd_en` high. Pulses one cycle apart are all executed.

## Structure
- **Package `lcd_pkg`:** command-class masks, `CHAR_SPACE` = 0x20, `ADDR_LINE1` = 0x40, the FSM state enum (IDLE, CLEAR), and the cell-index helper function.
- **Sub-module `lcd_ddram`:** 32×8 register file with one write port, a registered host read port and a combinational bus read port. Instantiated once.
- **Top level:** capture, decode and FSM.

## Test plan
- **Init and text:** write cmds 0x80, 0x38, 0x0C, then data 0x2B, 0x31, 0x32, 0x33 → cells 0–3 = 2B 31 32 33, `ac` = 4, `two_line` = 1, `disp_on` = 1, 3 `cmd_strobe` and 4 `wr_strobe` pulses.
- **Line 1:** cmd 0xC0, data 0x2D, then `rd_idx` = 16 → `rd_char` = 0x2D one cycle later. Status read → `lcd_dout` = 0x41.
- **Wrap:** cmd 0x8F, data 0x41, 0x42 → cell15 = 0x41, cell16 = 0x42. Cmd 0x04, cmd 0x80, data 0x5A → cell0 = 0x5A, `ac` = 31.
- **Clear and overrun:** cmd 0x01 → `busy` high for exactly 32 cycles and all cells 0x20 afterwards. A data write at busy cycle 5 → dropped and `ovr` pulses. A status read at busy cycle 6 → bit7 = 1.
- **Reset mid-clear:** assert `rst_n` = 0 at busy cycle 10 → `busy` = 0 asynchronously, all cells 0x20, `ac` = 0, `disp_on` = 0.
